// File: rtl/smoothing_averager.sv
// Laplacian smoothing pass: p' = p + sum over neighbours of ((n >>> s) - (p >>> s)),
// per component, streamed from the object/neighbour RAMs into the result RAM.
module smoothing_averager #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 9,
  parameter int MAX_NEIGHBOR_COUNT = 10,
  parameter int COMP               = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   vertex_count,
  input  logic [4:0]              weight_shift,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    RAM_OBJ_EN,
  output logic [ADDR_WIDTH-1:0]   RAM_OBJ_A,
  input  logic [DATA_WIDTH-1:0]   RAM_OBJ_Do,
  output logic                    RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0]   RAM_NBR_A,
  input  logic [DATA_WIDTH-1:0]   RAM_NBR_Do,
  output logic                    RAM_RES_EN,
  output logic [DATA_WIDTH/8-1:0] RAM_RES_WE,
  output logic [ADDR_WIDTH-1:0]   RAM_RES_A,
  output logic [DATA_WIDTH-1:0]   RAM_RES_Di
);
  localparam int ACC_W  = DATA_WIDTH + $clog2(MAX_NEIGHBOR_COUNT + 2) + 1;
  localparam int CNT_W  = $clog2(MAX_NEIGHBOR_COUNT + 1);
  localparam int STEP_W = $clog2(COMP + 1);
  localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(COMP);
  localparam logic [STEP_W-1:0]     STEP_WR   = STEP_W'(COMP - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_A     = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT + 1);
  localparam logic [ADDR_WIDTH-1:0] COMP_A    = ADDR_WIDTH'(COMP);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MAX_CNT   = DATA_WIDTH'(MAX_NEIGHBOR_COUNT);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RD_COUNT, RD_IDX, RD_NCOMP, RD_SELF, WRITE, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [STEP_W-1:0]       step_q, step_d, comp_idx;
  logic [ADDR_WIDTH-1:0]   vtx_q, vtx_d, vc_q, vc_d, idx_q, idx_d;
  logic [4:0]              shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, nbr_q, nbr_d;
  logic                    err_q, err_d;
  logic signed [ACC_W-1:0] acc_q [COMP];
  logic signed [ACC_W-1:0] acc_d [COMP];

  logic [ADDR_WIDTH-1:0]        step_a, nbr_a, row_base, self_addr, nbr_addr;
  logic signed [DATA_WIDTH-1:0] obj_s, obj_sh;
  logic signed [ACC_W-1:0]      p_ext, sh_ext, cnt_ext, self_term, wr_acc;

  // step_q walks the issue/consume pipeline; component k is consumed at step k+1
  assign comp_idx  = step_q - STEP_W'(1);
  assign step_a    = {{(ADDR_WIDTH-STEP_W){1'b0}}, step_q};
  assign nbr_a     = {{(ADDR_WIDTH-CNT_W){1'b0}}, nbr_q};
  assign row_base  = vtx_q * ROW_A;
  assign self_addr = vtx_q * COMP_A + ONE_A + step_a;
  assign nbr_addr  = (idx_q - ONE_A) * COMP_A + ONE_A + step_a;
  assign obj_s     = RAM_OBJ_Do;
  assign obj_sh    = obj_s >>> shift_q;
  assign p_ext     = {{(ACC_W-DATA_WIDTH){obj_s[DATA_WIDTH-1]}}, obj_s};
  assign sh_ext    = {{(ACC_W-DATA_WIDTH){obj_sh[DATA_WIDTH-1]}}, obj_sh};
  assign cnt_ext   = {{(ACC_W-CNT_W){1'b0}}, cnt_q};
  assign self_term = p_ext - cnt_ext * sh_ext;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    vtx_d      = vtx_q;
    vc_d       = vc_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    nbr_d      = nbr_q;
    idx_d      = idx_q;
    err_d      = err_q;
    acc_d      = acc_q;
    wr_acc     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    RAM_OBJ_EN = 1'b0;
    RAM_OBJ_A  = '0;
    RAM_NBR_EN = 1'b0;
    RAM_NBR_A  = '0;
    RAM_RES_EN = 1'b0;
    RAM_RES_WE = '0;
    RAM_RES_A  = '0;
    RAM_RES_Di = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vc_d    = vertex_count;
          shift_d = weight_shift;
          err_d   = 1'b0;
          vtx_d   = '0;
          step_d  = '0;
          state_d = RD_COUNT;
        end
      end
      RD_COUNT: begin
        busy = 1'b1;
        if (step_q == '0) begin
          if (vtx_q == vc_q) begin
            state_d = FINISH;
          end else begin
            RAM_NBR_EN = 1'b1;
            RAM_NBR_A  = row_base;
            step_d     = STEP_W'(1);
            for (int k = 0; k < COMP; k++) acc_d[k] = '0;
          end
        end else begin
          step_d = '0;
          nbr_d  = '0;
          // An oversized row is flagged and then handled exactly like an isolated vertex
          if (RAM_NBR_Do > MAX_CNT) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = RD_SELF;
          end else begin
            cnt_d   = RAM_NBR_Do[CNT_W-1:0];
            state_d = (RAM_NBR_Do == '0) ? RD_SELF : RD_IDX;
          end
        end
      end
      RD_IDX: begin
        busy = 1'b1;
        if (step_q == '0) begin
          RAM_NBR_EN = 1'b1;
          RAM_NBR_A  = row_base + ONE_A + nbr_a;
          step_d     = STEP_W'(1);
        end else begin
          idx_d   = RAM_NBR_Do[ADDR_WIDTH-1:0];
          step_d  = '0;
          state_d = RD_NCOMP;
        end
      end
      RD_NCOMP: begin
        busy = 1'b1;
        if (step_q != STEP_LAST) begin
          RAM_OBJ_EN = 1'b1;
          RAM_OBJ_A  = nbr_addr;
        end
        if (step_q != '0) acc_d[comp_idx] = acc_q[comp_idx] + sh_ext;
        if (step_q == STEP_LAST) begin
          step_d  = '0;
          nbr_d   = nbr_q + CNT_W'(1);
          state_d = (nbr_q + CNT_W'(1) == cnt_q) ? RD_SELF : RD_IDX;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      RD_SELF: begin
        busy = 1'b1;
        if (step_q != STEP_LAST) begin
          RAM_OBJ_EN = 1'b1;
          RAM_OBJ_A  = self_addr;
        end
        if (step_q != '0) acc_d[comp_idx] = acc_q[comp_idx] + self_term;
        if (step_q == STEP_LAST) begin
          step_d  = '0;
          state_d = WRITE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      WRITE: begin
        busy       = 1'b1;
        wr_acc     = acc_q[step_q];
        RAM_RES_EN = 1'b1;
        RAM_RES_WE = '1;
        RAM_RES_A  = self_addr;
        if (wr_acc > SAT_HI)      RAM_RES_Di = SAT_HI[DATA_WIDTH-1:0];
        else if (wr_acc < SAT_LO) RAM_RES_Di = SAT_LO[DATA_WIDTH-1:0];
        else                      RAM_RES_Di = wr_acc[DATA_WIDTH-1:0];
        if (step_q == STEP_WR) begin
          step_d  = '0;
          vtx_d   = vtx_q + ONE_A;
          state_d = (vtx_q + ONE_A == vc_q) ? FINISH : RD_COUNT;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      vtx_q   <= '0;
      vc_q    <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      nbr_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < COMP; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      vtx_q   <= vtx_d;
      vc_q    <= vc_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      nbr_q   <= nbr_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      for (int k = 0; k < COMP; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: tb/tb_smoothing_averager.sv
// Self-checking bench for smoothing_averager: RAM models, a plain-arithmetic
// reference of the smoothing rule, and directed plus randomized jobs.
module tb_smoothing_averager;
  localparam int DW   = 32;
  localparam int AW   = 9;
  localparam int MAXN = 10;
  localparam int NC   = 3;
  localparam int ROWS = MAXN + 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] vertex_count = '0;
  logic [4:0]    weight_shift = '0;
  logic          busy, done, err;
  logic          RAM_OBJ_EN, RAM_NBR_EN, RAM_RES_EN;
  logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A, RAM_RES_A;
  logic [DW-1:0] RAM_OBJ_Do = '0;
  logic [DW-1:0] RAM_NBR_Do = '0;
  logic [DW-1:0] RAM_RES_Di;
  logic [DW/8-1:0] RAM_RES_WE;

  logic [DW-1:0] obj_mem [512];
  logic [DW-1:0] nbr_mem [512];
  logic [DW-1:0] res_mem [512];
  logic [AW-1:0] wr_log [$];
  logic          obj_en_s = 1'b0, nbr_en_s = 1'b0;
  logic [AW-1:0] obj_a_s = '0, nbr_a_s = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int en_bad   = 0;
  int we_bad   = 0;
  int en_act   = 0;

  smoothing_averager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_NEIGHBOR_COUNT(MAXN), .COMP(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count), .weight_shift(weight_shift),
    .busy(busy), .done(done), .err(err),
    .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_A(RAM_OBJ_A), .RAM_OBJ_Do(RAM_OBJ_Do),
    .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_A(RAM_NBR_A), .RAM_NBR_Do(RAM_NBR_Do),
    .RAM_RES_EN(RAM_RES_EN), .RAM_RES_WE(RAM_RES_WE), .RAM_RES_A(RAM_RES_A), .RAM_RES_Di(RAM_RES_Di)
  );

  always #5 clk = ~clk;

  // Ports are sampled mid-cycle; read data appears one cycle after the address
  always @(negedge clk) begin
    obj_en_s = RAM_OBJ_EN;
    obj_a_s  = RAM_OBJ_A;
    nbr_en_s = RAM_NBR_EN;
    nbr_a_s  = RAM_NBR_A;
    if (RAM_OBJ_EN || RAM_NBR_EN || RAM_RES_EN) en_act++;
    if ((RAM_OBJ_EN || RAM_NBR_EN || RAM_RES_EN) && !busy) en_bad++;
    if (!RAM_RES_EN && RAM_RES_WE != '0) we_bad++;
    if (RAM_RES_EN && !rst) begin
      if (RAM_RES_WE != '1) we_bad++;
      res_mem[RAM_RES_A] = RAM_RES_Di;
      wr_log.push_back(RAM_RES_A);
    end
  end

  always @(posedge clk) begin
    if (obj_en_s) RAM_OBJ_Do <= obj_mem[obj_a_s];
    if (nbr_en_s) RAM_NBR_Do <= nbr_mem[nbr_a_s];
  end

  task automatic clear_mems();
    for (int i = 0; i < 512; i++) begin
      obj_mem[i] = '0;
      nbr_mem[i] = '0;
      res_mem[i] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic clear_res();
    for (int i = 0; i < 512; i++) res_mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic set_vertex(input int v, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
    obj_mem[v*NC+1] = x;
    obj_mem[v*NC+2] = y;
    obj_mem[v*NC+3] = z;
  endtask

  task automatic build_pair();
    clear_mems();
    set_vertex(0, 32'h0001_0000, 0, 0);
    set_vertex(1, 32'h0003_0000, 0, 0);
    nbr_mem[0] = 1;  nbr_mem[1] = 2;
    nbr_mem[ROWS] = 1;  nbr_mem[ROWS+1] = 1;
  endtask

  // Reference: p + sum((n >>> s) - (p >>> s)) in 64-bit, then clamp to the data range
  function automatic logic [DW-1:0] model_comp(input int v, input int k, input int s);
    longint p, q, acc;
    int c, n;
    p = longint'($signed(obj_mem[v*NC+1+k]));
    c = int'(nbr_mem[v*ROWS]);
    if (c > MAXN || c < 0) c = 0;
    acc = p;
    for (int j = 1; j <= c; j++) begin
      n = int'(nbr_mem[v*ROWS+j]);
      q = longint'($signed(obj_mem[(n-1)*NC+1+k]));
      acc += (q >>> s) - (p >>> s);
    end
    if (acc > SMAX) return 32'h7FFF_FFFF;
    if (acc < SMIN) return 32'h8000_0000;
    return acc[DW-1:0];
  endfunction

  function automatic int exp_latency(input int vc);
    int total, c;
    if (vc == 0) return 2;
    total = 1;
    for (int v = 0; v < vc; v++) begin
      c = int'(nbr_mem[v*ROWS]);
      if (c > MAXN || c < 0) c = 0;
      total += 2 + c*(NC+3) + (NC+1) + NC;
    end
    return total;
  endfunction

  // latency counts cycles from the accepting edge to the done cycle (-1 on timeout)
  task automatic run_job(input int vc, input int s, input int extra_at, input bit start_on_done,
                         output int latency, output int ndone, output bit busy_ok);
    wr_log.delete();
    @(posedge clk); #1;
    start = 1'b1; vertex_count = AW'(vc); weight_shift = 5'(s);
    @(posedge clk); #1;
    start = 1'b0;
    latency = -1; ndone = 0; busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      start = (cyc == extra_at);
      vertex_count = (cyc == extra_at) ? AW'(vc + 3) : AW'(vc);
      if (done) begin
        ndone++;
        latency = cyc;
        if (busy) busy_ok = 1'b0;
        start = start_on_done;
        @(posedge clk); #1;
        start = 1'b0;
        if (done) ndone++;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, err});
    end
    n_checks++;
    if ({RAM_OBJ_EN, RAM_NBR_EN, RAM_RES_EN, RAM_RES_WE} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_enables: got %b expected 0", {RAM_OBJ_EN, RAM_NBR_EN, RAM_RES_EN, RAM_RES_WE});
    end
    n_checks++;
    if ({RAM_OBJ_A, RAM_NBR_A, RAM_RES_A, RAM_RES_Di} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_addr_data: got %h expected 0", {RAM_OBJ_A, RAM_NBR_A, RAM_RES_A, RAM_RES_Di});
    end
    rst = 1'b0;
  endtask

  task automatic test_pair();
    int lat, nd;
    bit bok;
    logic [DW-1:0] exp_v [6];
    exp_v = '{32'h0001_2000, 0, 0, 32'h0002_E000, 0, 0};
    build_pair();
    run_job(2, 4, 0, 1'b0, lat, nd, bok);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (res_mem[i+1] !== exp_v[i]) begin
        n_fail++; $display("[TB] FAIL pair_res[%0d]: got %h expected %h", i+1, res_mem[i+1], exp_v[i]);
      end
    end
    n_checks++;
    if (nd !== 1 || err !== 1'b0 || !bok) begin
      n_fail++; $display("[TB] FAIL pair_handshake: got done=%0d err=%b busy_ok=%b expected 1 0 1", nd, err, bok);
    end
    n_checks++;
    if (lat !== 31) begin
      n_fail++; $display("[TB] FAIL pair_latency: got %0d expected 31", lat);
    end
  endtask

  task automatic test_negative_and_saturation();
    int lat, nd;
    bit bok;
    clear_mems();
    set_vertex(0, 32'hFFFF_0000, 0, 0);
    nbr_mem[0] = 1; nbr_mem[1] = 2;
    run_job(2, 4, 0, 1'b0, lat, nd, bok);
    n_checks++;
    if (res_mem[1] !== 32'hFFFF_1000) begin
      n_fail++; $display("[TB] FAIL negative_x: got %h expected ffff1000", res_mem[1]);
    end
    for (int m = 0; m < 2; m++) begin
      clear_mems();
      set_vertex(1, (m == 0) ? 32'h7FFF_0000 : 32'h8001_0000, 0, 0);
      set_vertex(2, (m == 0) ? 32'h7FFF_0000 : 32'h8001_0000, 0, 0);
      nbr_mem[0] = 2; nbr_mem[1] = 2; nbr_mem[2] = 3;
      run_job(3, 0, 0, 1'b0, lat, nd, bok);
      n_checks++;
      if (res_mem[1] !== ((m == 0) ? 32'h7FFF_FFFF : 32'h8000_0000)) begin
        n_fail++; $display("[TB] FAIL saturate_%0d: got %h expected %h", m, res_mem[1],
                           (m == 0) ? 32'h7FFF_FFFF : 32'h8000_0000);
      end
    end
  endtask

  task automatic test_malformed();
    int lat, nd;
    bit bok;
    logic [DW-1:0] e;
    clear_mems();
    for (int v = 0; v < 4; v++) set_vertex(v, $urandom, $urandom, $urandom);
    nbr_mem[0] = 12;
    for (int j = 1; j <= MAXN; j++) nbr_mem[j] = 3;
    nbr_mem[ROWS] = 0;
    nbr_mem[2*ROWS] = 1; nbr_mem[2*ROWS+1] = 4;
    nbr_mem[3*ROWS] = 2; nbr_mem[3*ROWS+1] = 3; nbr_mem[3*ROWS+2] = 2;
    run_job(4, 3, 0, 1'b0, lat, nd, bok);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL malformed_err: got %b expected 1", err);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (res_mem[i+1] !== obj_mem[i+1]) begin
        n_fail++; $display("[TB] FAIL copy_unchanged[%0d]: got %h expected %h", i+1, res_mem[i+1], obj_mem[i+1]);
      end
    end
    for (int v = 2; v < 4; v++) begin
      for (int k = 0; k < NC; k++) begin
        e = model_comp(v, k, 3);
        n_checks++;
        if (res_mem[v*NC+1+k] !== e) begin
          n_fail++; $display("[TB] FAIL malformed_job v%0d.%0d: got %h expected %h", v, k, res_mem[v*NC+1+k], e);
        end
      end
    end
    n_checks++;
    if (lat !== exp_latency(4)) begin
      n_fail++; $display("[TB] FAIL malformed_latency: got %0d expected %0d", lat, exp_latency(4));
    end
    run_job(0, 0, 0, 1'b0, lat, nd, bok);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL err_clear: got %b expected 0", err);
    end
  endtask

  task automatic test_control();
    int lat, nd, en0;
    bit bok, order_ok;
    build_pair();
    en0 = en_act;
    run_job(0, 4, 0, 1'b0, lat, nd, bok);
    n_checks++;
    if (lat !== 2 || nd !== 1 || !bok) begin
      n_fail++; $display("[TB] FAIL zero_vertices: got lat=%0d done=%0d busy_ok=%b expected 2 1 1", lat, nd, bok);
    end
    n_checks++;
    if (en_act !== en0 || wr_log.size() !== 0) begin
      n_fail++; $display("[TB] FAIL zero_vertices_ram: got %0d enables %0d writes expected 0 0", en_act - en0, wr_log.size());
    end
    run_job(2, 4, 5, 1'b0, lat, nd, bok);
    order_ok = (wr_log.size() == 6);
    for (int i = 0; i < wr_log.size() && i < 6; i++) if (wr_log[i] !== AW'(i + 1)) order_ok = 1'b0;
    n_checks++;
    if (!order_ok || lat !== 31 || nd !== 1) begin
      n_fail++; $display("[TB] FAIL start_while_busy: got writes=%0d order_ok=%b lat=%0d expected 6 1 31", wr_log.size(), order_ok, lat);
    end
    n_checks++;
    if (res_mem[4] !== 32'h0002_E000) begin
      n_fail++; $display("[TB] FAIL start_while_busy_res: got %h expected 0002e000", res_mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nd, wait_cyc;
    bit bok, accepted;
    build_pair();
    run_job(2, 4, 0, 1'b1, lat, nd, bok);
    n_checks++;
    if (!bok || nd !== 1) begin
      n_fail++; $display("[TB] FAIL start_on_done_ignored: got busy_ok=%b done=%0d expected 1 1", bok, nd);
    end
    clear_res();
    start = 1'b1; vertex_count = 2; weight_shift = 4;
    @(posedge clk); #1;
    start = 1'b0;
    accepted = busy;
    wait_cyc = 0;
    while (!done && wait_cyc < 200) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    n_checks++;
    if (!accepted || !done) begin
      n_fail++; $display("[TB] FAIL start_after_done: got accepted=%b done=%b expected 1 1", accepted, done);
    end
    n_checks++;
    if (res_mem[1] !== 32'h0001_2000) begin
      n_fail++; $display("[TB] FAIL back_to_back_res: got %h expected 00012000", res_mem[1]);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat, nd;
    bit bok, hit;
    build_pair();
    wr_log.delete();
    @(posedge clk); #1;
    start = 1'b1; vertex_count = 2; weight_shift = 4;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_log.size() == NC && RAM_RES_EN) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("[TB] FAIL reset_mid_reach: got 0 expected 1");
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, err, RAM_OBJ_EN, RAM_NBR_EN, RAM_RES_EN, RAM_RES_WE, RAM_RES_A, RAM_RES_Di} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_mid_outputs: got %h expected 0",
                         {busy, done, err, RAM_OBJ_EN, RAM_NBR_EN, RAM_RES_EN, RAM_RES_WE, RAM_RES_A, RAM_RES_Di});
    end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (wr_log.size() !== NC || res_mem[4] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL reset_mid_no_writes: got %0d writes v1.x=%h expected 3 deadbeef", wr_log.size(), res_mem[4]);
    end
    clear_res();
    run_job(2, 4, 0, 1'b0, lat, nd, bok);
    n_checks++;
    if (res_mem[1] !== 32'h0001_2000 || res_mem[4] !== 32'h0002_E000 || lat !== 31) begin
      n_fail++; $display("[TB] FAIL reset_restart: got %h %h lat=%0d expected 00012000 0002e000 31", res_mem[1], res_mem[4], lat);
    end
  endtask

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return DW'($urandom_range(0, 65535)) - 32'd32768;
      2:       return {16'h7FFF, 16'($urandom)};
      default: return {16'h8000, 16'($urandom)};
    endcase
  endfunction

  task automatic test_random();
    int lat, nd, nv, s, c, r;
    bit bok, exp_err;
    logic [DW-1:0] e;
    for (int job = 0; job < 8; job++) begin
      clear_mems();
      nv = $urandom_range(1, 6);
      s = $urandom_range(0, 31);
      exp_err = 1'b0;
      for (int v = 0; v < nv; v++) begin
        set_vertex(v, rnd_val(), rnd_val(), rnd_val());
        r = $urandom_range(0, 9);
        c = (r == 0) ? $urandom_range(11, 15) : $urandom_range(0, (r < 4) ? MAXN : 3);
        if (c > MAXN) exp_err = 1'b1;
        nbr_mem[v*ROWS] = c;
        for (int j = 1; j <= c && j <= MAXN; j++) nbr_mem[v*ROWS+j] = $urandom_range(1, nv);
      end
      run_job(nv, s, 0, 1'b0, lat, nd, bok);
      for (int v = 0; v < nv; v++) begin
        for (int k = 0; k < NC; k++) begin
          e = model_comp(v, k, s);
          n_checks++;
          if (res_mem[v*NC+1+k] !== e) begin
            n_fail++; $display("[TB] FAIL random_job%0d v%0d.%0d s=%0d: got %h expected %h", job, v, k, s, res_mem[v*NC+1+k], e);
          end
        end
      end
      n_checks++;
      if (lat !== exp_latency(nv) || nd !== 1 || !bok || err !== exp_err || wr_log.size() !== nv*NC) begin
        n_fail++; $display("[TB] FAIL random_job%0d_ctrl: got lat=%0d done=%0d busy_ok=%b err=%b writes=%0d expected %0d 1 1 %b %0d",
                           job, lat, nd, bok, err, wr_log.size(), exp_latency(nv), exp_err, nv*NC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_negative_and_saturation();
    test_malformed();
    test_control();
    test_back_to_back();
    test_reset_mid_job();
    test_random();
    n_checks++;
    if (en_bad !== 0 || we_bad !== 0) begin
      n_fail++; $display("[TB] FAIL port_protocol: got en_bad=%0d we_bad=%0d expected 0 0", en_bad, we_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smoothing_averager.md
Name: smoothing_averager

Overview:
- Parametrised successor to the single-pass Laplacian averager used in the subdivision pipeline. For every vertex it computes p' = p + sum over neighbours n of ((n >>> s) - (p >>> s)), per component, and writes the result to the result RAM.
- New relative to the previous generation:
  - runtime weight shift
  - configurable component count, data width and neighbour depth
  - saturating wide accumulators
  - malformed-row error flag
  - done pulse
  - clean asynchronous reset.
- Sits between the object/neighbour RAMs and the result RAM. It is started by the top-level sequencer.

Parameters:
- DATA_WIDTH, 32: signed fixed-point component width (Q16.16 at default).
- ADDR_WIDTH, 9: address width of all three RAMs.
- MAX_NEIGHBOR_COUNT, 10: maximum neighbours per vertex. Neighbour row stride is MAX_NEIGHBOR_COUNT+1.
- COMP, 3: components per vertex.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request; sampled in IDLE only.
- vertex_count  in  ADDR_WIDTH  vertices to process; latched on accepted start.
- weight_shift  in  5  s; latched on start; legal 0..DATA_WIDTH-1.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky; set when any row count > MAX_NEIGHBOR_COUNT; cleared on next accepted start.
- RAM_OBJ_EN / RAM_OBJ_A  out  1 / ADDR_WIDTH  object RAM read port.
- RAM_OBJ_Do  in  DATA_WIDTH  object RAM data, valid the cycle after address.
- RAM_NBR_EN / RAM_NBR_A  out  1 / ADDR_WIDTH  neighbour RAM read port.
- RAM_NBR_Do  in  DATA_WIDTH  neighbour RAM data, 1-cycle latency.
- RAM_RES_EN / RAM_RES_WE / RAM_RES_A / RAM_RES_Di  out  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  result RAM write port.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators 0. Reset mid-job aborts immediately with no further writes. A new start is accepted afterwards.
- Memory map:
  - Vertex v (0-based), component k is at object/result address v*COMP+1+k.
  - Neighbour row v starts at v*(MAX_NEIGHBOR_COUNT+1). The word at that address is count c; the next c words are 1-based neighbour indices.
- States: IDLE -> RD_COUNT -> (RD_IDX -> RD_NCOMP)*c -> RD_SELF -> WRITE -> RD_COUNT (next vertex) or FINISH -> IDLE.
- Reads: address is driven in cycle t and data is consumed in cycle t+1. Component reads are pipelined back to back.
- Per-vertex cycle count is exactly 2 + c*(COMP+3) + (COMP+1) + COMP, with c taken as 0 for rows in error.
- Arithmetic:
  - Accumulator width ACC_W = DATA_WIDTH + clog2(MAX_NEIGHBOR_COUNT+2) + 1, signed; one accumulator per component.
  - Cleared at RD_COUNT.
  - Each neighbour adds sign-extended (n >>> s).
  - RD_SELF adds p - c*(p >>> s), computed exactly in ACC_W.
  - Shifts are arithmetic and truncate toward minus infinity.
  - On write, the accumulator is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- WRITE: COMP consecutive cycles with RAM_RES_WE all-ones and ascending addresses, component 0 first. WE is 0 in every other cycle.
- Boundary cases:
  - c = 0: vertex is written unchanged.
  - c > MAX_NEIGHBOR_COUNT: err is set, the row is treated as c = 0 and the vertex is written unchanged; the job continues.
  - vertex_count = 0: done pulses 2 cycles after start; no RAM access.
  - Neighbour index 0 or > vertex_count is not checked; behaviour is undefined.
- Handshake:
  - start while busy is ignored.
  - done pulses in FINISH, in the same cycle busy falls.
  - start coincident with done is ignored; a new start is accepted from the cycle after done.
- The object RAM is never written. RAM_*_EN is high only while busy.

Test Plan:
- 2 vertices, s=4: v0.x=0x00010000, v1.x=0x00030000, each neighbour of the other, y=z=0 -> res v0.x=0x00012000, v1.x=0x0002E000, y/z=0, done pulses once, err=0.
- Negative values, s=4: v0=(0xFFFF0000,0,0) with one neighbour at (0,0,0) -> v0.x=0xFFFF1000.
- Saturation, s=0: v0=(0,..), 2 neighbours at x=0x7FFF0000 -> v0.x=0x7FFFFFFF. Mirror case with 0x80010000 neighbours -> 0x80000000.
- Malformed and isolated rows: row count 12 with MAX_NEIGHBOR_COUNT=10 -> err=1 and vertex copied unchanged. An isolated vertex (c=0) -> copied unchanged. Remaining vertices are processed normally. err clears on the next start.
- Control: vertex_count=0 -> done 2 cycles after start with no EN/WE activity. start asserted while busy -> ignored, with write count and order unchanged.
- Reset mid-job: rst asserted during WRITE of vertex 1 -> all outputs 0 within the same cycle, no further writes. A restarted job then produces the same results as an uninterrupted run.
